dac7611_serializer: RTL and testbench

- Upstream driver for the dual-channel DAC7611 serial interface.
- Accepts one pair of 12-bit samples per frame over a valid/ready handshake.
- Shifts both channels out MSB-first in parallel on two data lines, with a generated serial clock.
- Then pulses the active-low load strobe, which latches the frame into the DAC on the strobe's rising edge.

---
 rtl/dac7611_serializer.sv | 144 ++++++++++++++
 tb/tb_dac7611_serializer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac7611_serializer.sv
// dac7611_serializer
// Drives the dual-channel DAC7611 serial interface. One pair of 12-bit samples
// is accepted per frame, shifted out MSB-first on two parallel data lines with a
// generated serial clock, and then latched into the DAC with an active-low load
// strobe. Every output comes straight from a flop.

module dac7611_serializer #(
  parameter int unsigned CLK_DIV   = 2,  // system clocks per serial-clock half period
  parameter int unsigned LD_CYCLES = 2   // system clocks the load strobe is held low
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sample_1,
  input  logic [11:0] sample_2,
  input  logic        valid,
  output logic        ready,
  output logic        dac_clk,
  output logic        dac_dat1,
  output logic        dac_dat2,
  output logic        dac_leb,
  output logic        frame_done
);

  // Out-of-range parameters are pulled back into 1..255 so the 8-bit
  // countdowns can never wrap or stall.
  localparam int unsigned CLK_DIV_L =
    (CLK_DIV < 32'd1) ? 32'd1 : ((CLK_DIV > 32'd255) ? 32'd255 : CLK_DIV);
  localparam int unsigned LD_CYCLES_L =
    (LD_CYCLES < 32'd1) ? 32'd1 : ((LD_CYCLES > 32'd255) ? 32'd255 : LD_CYCLES);

  // Countdown reload values: a phase lasting N cycles starts at N-1 and ends at 0.
  localparam logic [7:0] HALF_RELOAD = 8'(CLK_DIV_L - 32'd1);
  localparam logic [7:0] LOAD_RELOAD = 8'(LD_CYCLES_L - 32'd1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LOAD     = 2'd3
  } state_t;

  state_t      state_r;
  logic [7:0]  cnt_r;      // half-period / load-strobe countdown
  logic [3:0]  idx_r;      // bit currently presented on the data lines
  logic [11:0] shreg1_r;   // channel 1 sample captured at accept
  logic [11:0] shreg2_r;   // channel 2 sample captured at accept

  // Frame sequencer: accept, twelve serial bits, load strobe, back to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 8'd0;
      idx_r      <= 4'd0;
      shreg1_r   <= 12'd0;
      shreg2_r   <= 12'd0;
      ready      <= 1'b0;
      dac_clk    <= 1'b0;
      dac_dat1   <= 1'b0;
      dac_dat2   <= 1'b0;
      dac_leb    <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      // frame_done is a single-cycle pulse; only the end of LOAD raises it.
      frame_done <= 1'b0;
      case (state_r)
        IDLE: begin
          dac_clk <= 1'b0;
          dac_leb <= 1'b1;
          if (valid && ready) begin
            // Samples are captured only here, so later input changes are ignored.
            shreg1_r <= sample_1;
            shreg2_r <= sample_2;
            idx_r    <= 4'd11;
            cnt_r    <= HALF_RELOAD;
            dac_dat1 <= sample_1[11];
            dac_dat2 <= sample_2[11];
            ready    <= 1'b0;
            state_r  <= SHIFT_LO;
          end else begin
            ready <= 1'b1;
          end
        end

        SHIFT_LO: begin
          // Data is already stable; this phase provides setup before the rising edge.
          if (cnt_r == 8'd0) begin
            cnt_r   <= HALF_RELOAD;
            dac_clk <= 1'b1;
            state_r <= SHIFT_HI;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end

        SHIFT_HI: begin
          // Data is held through the high phase; it only moves as dac_clk falls.
          if (cnt_r == 8'd0) begin
            dac_clk <= 1'b0;
            if (idx_r != 4'd0) begin
              idx_r    <= idx_r - 4'd1;
              dac_dat1 <= shreg1_r[idx_r - 4'd1];
              dac_dat2 <= shreg2_r[idx_r - 4'd1];
              cnt_r    <= HALF_RELOAD;
              state_r  <= SHIFT_LO;
            end else begin
              dac_dat1 <= 1'b0;
              dac_dat2 <= 1'b0;
              dac_leb  <= 1'b0;
              cnt_r    <= LOAD_RELOAD;
              state_r  <= LOAD;
            end
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end

        LOAD: begin
          // The DAC latches on the rising edge of dac_leb at the end of this phase.
          if (cnt_r == 8'd0) begin
            dac_leb    <= 1'b1;
            frame_done <= 1'b1;
            ready      <= 1'b1;
            state_r    <= IDLE;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end

        default: begin
          // Unreachable encoding: park in a safe idle state with no load pending.
          state_r  <= IDLE;
          cnt_r    <= 8'd0;
          idx_r    <= 4'd0;
          ready    <= 1'b0;
          dac_clk  <= 1'b0;
          dac_dat1 <= 1'b0;
          dac_dat2 <= 1'b0;
          dac_leb  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac7611_serializer.sv
// Bench for dac7611_serializer. Lane 0 runs CLK_DIV=2/LD_CYCLES=2, lane 1 runs
// CLK_DIV=1/LD_CYCLES=1. A behavioural DAC model per lane shifts data on rising
// dac_clk and latches on rising dac_leb; expected pairs are queued at accept.

module tb_dac7611_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] s1    [2];
  logic [11:0] s2    [2];
  logic        valid [2];
  logic        ready [2];
  logic        dclk  [2];
  logic        d1    [2];
  logic        d2    [2];
  logic        leb   [2];
  logic        fdone [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    dac7611_serializer #(
      .CLK_DIV   ((g == 0) ? 2 : 1),
      .LD_CYCLES ((g == 0) ? 2 : 1)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .sample_1   (s1[g]),
      .sample_2   (s2[g]),
      .valid      (valid[g]),
      .ready      (ready[g]),
      .dac_clk    (dclk[g]),
      .dac_dat1   (d1[g]),
      .dac_dat2   (d2[g]),
      .dac_leb    (leb[g]),
      .frame_done (fdone[g])
    );
  end

  typedef struct packed {
    logic [1:0]  lane;
    logic [23:0] data;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor state (written only by the monitor block)
  logic [11:0] sh1 [2];
  logic [11:0] sh2 [2];
  logic        dclk_q [2];
  logic        leb_q  [2];
  int rises [2], rise_total [2], clk_in_load [2];
  int hi_run [2], last_hi [2], leb_lo [2], last_leb [2];
  int lo_cnt [2], last_lo [2], fd_n [2], acc_n [2], period [2];
  time last_acc [2];
  logic [23:0] obs_log  [2][64];
  int          rise_log [2][64];
  int          obs_n [2];
  int          rd [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      sh1[g] = 12'd0; sh2[g] = 12'd0; dclk_q[g] = 1'b0; leb_q[g] = 1'b1;
      rises[g] = 0; rise_total[g] = 0; clk_in_load[g] = 0; hi_run[g] = 0;
      last_hi[g] = 0; leb_lo[g] = 0; last_leb[g] = 0; lo_cnt[g] = 0;
      last_lo[g] = 0; fd_n[g] = 0; acc_n[g] = 0; period[g] = 0;
      last_acc[g] = 0; obs_n[g] = 0;
    end
  end

  // DAC model and timing monitor, sampled on the falling clk edge.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        rises[g] = 0; hi_run[g] = 0; leb_lo[g] = 0; lo_cnt[g] = 0;
      end else begin
        if (dclk[g] && !dclk_q[g]) begin
          sh1[g] = {sh1[g][10:0], d1[g]};
          sh2[g] = {sh2[g][10:0], d2[g]};
          rises[g]++;
          rise_total[g]++;
          if (!leb[g]) clk_in_load[g]++;
        end
        if (dclk[g]) hi_run[g]++;
        else if (hi_run[g] != 0) begin last_hi[g] = hi_run[g]; hi_run[g] = 0; end
        if (!leb[g]) leb_lo[g]++;
        else if (leb_lo[g] != 0) begin last_leb[g] = leb_lo[g]; leb_lo[g] = 0; end
        if (leb[g] && !leb_q[g]) begin
          obs_log[g][obs_n[g]]  = {sh1[g], sh2[g]};
          rise_log[g][obs_n[g]] = rises[g];
          obs_n[g]++;
          rises[g] = 0;
        end
        if (!ready[g]) lo_cnt[g]++;
        else if (lo_cnt[g] != 0) begin last_lo[g] = lo_cnt[g]; lo_cnt[g] = 0; end
        if (fdone[g]) fd_n[g]++;
        // Inputs are stable here, so valid&&ready now means accept at the next edge.
        if (valid[g] && ready[g]) begin
          if (acc_n[g] > 0) period[g] = int'(($time - last_acc[g]) / 10);
          last_acc[g] = $time;
          acc_n[g]++;
        end
      end
      dclk_q[g] = dclk[g];
      leb_q[g]  = leb[g];
    end
  end

  task automatic send(input int g, input logic [11:0] a, input logic [11:0] b);
    int   n0;
    exp_t e;
    n0 = acc_n[g];
    @(posedge clk); #2;
    s1[g] = a; s2[g] = b; valid[g] = 1'b1;
    for (int i = 0; i < 200 && acc_n[g] == n0; i++) begin
      @(negedge clk); #1;
    end
    if (acc_n[g] == n0) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      e.lane = 2'(g);
      e.data = {a, b};
      exp_q.push_back(e);
    end
  endtask

  task automatic drop(input int g);
    @(posedge clk); #2;
    valid[g] = 1'b0;
  endtask

  task automatic wait_idle(input int g);
    @(negedge clk); #1;
    for (int i = 0; i < 300 && !ready[g]; i++) begin
      @(negedge clk); #1;
    end
    chk("idle_timeout", ready[g], 1'b1);
  endtask

  task automatic check_data(input int g);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("sb_lane", e.lane, 2'(g));
      if (rd[g] >= obs_n[g]) begin
        chk("no_load", obs_n[g], rd[g] + 1);
      end else begin
        chk("latch_ch1", obs_log[g][rd[g]][23:12], e.data[23:12]);
        chk("latch_ch2", obs_log[g][rd[g]][11:0],  e.data[11:0]);
        chk("rises_per_frame", rise_log[g][rd[g]], 32'd12);
        rd[g]++;
      end
    end
  endtask

  task automatic check_timing(input int g, input int lo, input int ld, input int hi);
    chk("ready_low_cycles", last_lo[g], lo);
    chk("leb_low_cycles", last_leb[g], ld);
    chk("dac_clk_high_cycles", last_hi[g], hi);
  endtask

  task automatic check_reset_outputs(input int g);
    chk("rst_ready", ready[g], 1'b0);
    chk("rst_dac_clk", dclk[g], 1'b0);
    chk("rst_dat1", d1[g], 1'b0);
    chk("rst_dat2", d2[g], 1'b0);
    chk("rst_leb", leb[g], 1'b1);
    chk("rst_frame_done", fdone[g], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          fd0, n, obs0;
    logic        prev;
    logic [23:0] last_latch;
    rd[0] = 0; rd[1] = 0;
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      s1[g] = 12'd0; s2[g] = 12'd0; valid[g] = 1'b0;
    end

    // Reset values and release
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs(0);
    check_reset_outputs(1);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_first_edge", ready[0], 1'b1);
    chk("ready_first_edge_l1", ready[1], 1'b1);
    repeat (100) @(posedge clk);
    #1;
    chk("idle_no_dac_clk", rise_total[0], 32'd0);
    chk("idle_no_dac_clk_l1", rise_total[1], 32'd0);
    chk("idle_no_load", obs_n[0], 32'd0);
    chk("idle_no_frame_done", fd_n[0], 32'd0);
    chk("idle_leb", leb[0], 1'b1);
    chk("idle_dac_clk", dclk[0], 1'b0);

    // Single frame with a one-cycle valid
    fd0 = fd_n[0];
    send(0, 12'hA5C, 12'h3F0);
    drop(0);
    wait_idle(0);
    check_data(0);
    check_timing(0, 50, 2, 2);
    chk("frame_done_single", fd_n[0] - fd0, 32'd1);

    // Back-to-back with valid held
    fd0 = fd_n[0];
    send(0, 12'hFFF, 12'h000);
    send(0, 12'h001, 12'h800);
    drop(0);
    wait_idle(0);
    check_data(0);
    check_data(0);
    check_timing(0, 50, 2, 2);
    chk("frame_period", period[0], 32'd51);
    chk("frame_done_b2b", fd_n[0] - fd0, 32'd2);

    // Inputs change every cycle mid-frame
    send(0, 12'h123, 12'h456);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #2;
      valid[0] = 1'b0;
      s1[0] = 12'($urandom);
      s2[0] = 12'($urandom);
    end
    wait_idle(0);
    check_data(0);

    // Reset on the 6th rising dac_clk of a frame
    last_latch = obs_log[0][obs_n[0] - 1];
    obs0 = obs_n[0];
    send(0, 12'h9C3, 12'h2B7);
    drop(0);
    n = 0;
    prev = dclk[0];
    for (int i = 0; i < 300 && n < 6; i++) begin
      @(posedge clk); #1;
      if (dclk[0] && !prev) n++;
      prev = dclk[0];
    end
    chk("six_rises_seen", n, 32'd6);
    rst = 1'b1;
    #1;
    check_reset_outputs(0);
    void'(exp_q.pop_back());
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("no_load_on_abort", obs_n[0], obs0);
    chk("latch_kept", obs_log[0][obs_n[0] - 1], last_latch);
    send(0, 12'h6E1, 12'h19D);
    drop(0);
    wait_idle(0);
    check_data(0);
    check_timing(0, 50, 2, 2);

    // Lane 1: CLK_DIV=1, LD_CYCLES=1
    send(1, 12'h555, 12'hAAA);
    drop(1);
    wait_idle(1);
    check_data(1);
    check_timing(1, 25, 1, 1);

    chk("dac_clk_in_load", clk_in_load[0] + clk_in_load[1], 32'd0);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
